// File: rtl/load_config_reg_hinp4_if.sv
// Slow-control bus between the board controller and the HINP4 config/DAC sequencer.
// Controller drives the request and data; sequencer drives the chip pins and status.
interface load_config_reg_hinp4_if #(
  parameter int CFG_BITS = 32,
  parameter int NUM_DACS = 16
);
  logic                  start;
  logic [CFG_BITS-1:0]   cfg_word;
  logic [6*NUM_DACS-1:0] dac_values;
  logic                  sinp;
  logic                  sclk;
  logic                  sel_ext_addr;
  logic                  dac_stb;
  logic [4:0]            dac_data;
  logic                  dac_sgn;
  logic                  busy;
  logic                  done;

  modport master (
    output start, cfg_word, dac_values,
    input  sinp, sclk, sel_ext_addr, dac_stb, dac_data, dac_sgn, busy, done
  );

  modport slave (
    input  start, cfg_word, dac_values,
    output sinp, sclk, sel_ext_addr, dac_stb, dac_data, dac_sgn, busy, done
  );
endinterface

// File: rtl/load_config_reg_hinp4.sv
// HINP4 power-up sequencer: serial config load, then NUM_DACS DAC writes; outputs registered, 1-cycle start latency.
// No backpressure: start is a request honoured only when idle, never queued.
module load_config_reg_hinp4 #(
  parameter int CFG_BITS = 32,
  parameter int NUM_DACS = 16,
  parameter int DIV      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  load_config_reg_hinp4_if.slave       bus
);
  localparam int              BW       = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int              CW       = (NUM_DACS > 1) ? $clog2(NUM_DACS) : 1;
  localparam logic [7:0]      DIV_LAST = 8'(DIV - 1);
  localparam logic [BW-1:0]   BIT_MSB  = BW'(CFG_BITS - 1);
  localparam logic [CW-1:0]   CH_LAST  = CW'(NUM_DACS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_DAC, S_FIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_div, w_div_nxt;
  logic [1:0]            r_ph, w_ph_nxt;
  logic [BW-1:0]         r_bit, w_bit_nxt;
  logic [CW-1:0]         r_ch, w_ch_nxt;
  logic [CFG_BITS-1:0]   r_cfg, w_cfg_nxt;
  logic [6*NUM_DACS-1:0] r_dac, w_dac_nxt;
  logic                  w_slot_end;
  logic [5:0]            w_dac_val;

  logic       r_sinp, r_sclk, r_sel, r_stb, r_sgn, r_busy, r_done;
  logic [4:0] r_data;
  logic       w_sinp_nxt, w_sclk_nxt, w_sel_nxt, w_stb_nxt, w_sgn_nxt, w_busy_nxt, w_done_nxt;
  logic [4:0] w_data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_ph    <= '0;
      r_bit   <= '0;
      r_ch    <= '0;
      r_cfg   <= '0;
      r_dac   <= '0;
      r_sinp  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sel   <= 1'b0;
      r_stb   <= 1'b0;
      r_data  <= '0;
      r_sgn   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_ph    <= w_ph_nxt;
      r_bit   <= w_bit_nxt;
      r_ch    <= w_ch_nxt;
      r_cfg   <= w_cfg_nxt;
      r_dac   <= w_dac_nxt;
      r_sinp  <= w_sinp_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sel   <= w_sel_nxt;
      r_stb   <= w_stb_nxt;
      r_data  <= w_data_nxt;
      r_sgn   <= w_sgn_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // r_div counts cycles within a half/third slot; r_ph selects which part of the slot we are in.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_ph_nxt    = r_ph;
    w_bit_nxt   = r_bit;
    w_ch_nxt    = r_ch;
    w_cfg_nxt   = r_cfg;
    w_dac_nxt   = r_dac;
    w_slot_end  = (r_div == DIV_LAST);

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_CFG;
          w_div_nxt   = '0;
          w_ph_nxt    = '0;
          w_bit_nxt   = BIT_MSB;
          w_ch_nxt    = '0;
          w_cfg_nxt   = bus.cfg_word;
          w_dac_nxt   = bus.dac_values;
        end
      end
      S_CFG: begin
        if (w_slot_end) begin
          w_div_nxt = '0;
          if (r_ph == 2'd1) begin
            w_ph_nxt = '0;
            if (r_bit == '0) w_state_nxt = S_DAC;
            else             w_bit_nxt   = r_bit - BW'(1);
          end else begin
            w_ph_nxt = 2'd1;
          end
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      S_DAC: begin
        if (w_slot_end) begin
          w_div_nxt = '0;
          if (r_ph == 2'd2) begin
            w_ph_nxt = '0;
            if (r_ch == CH_LAST) w_state_nxt = S_FIN;
            else                 w_ch_nxt    = r_ch + CW'(1);
          end else begin
            w_ph_nxt = r_ph + 2'd1;
          end
        end else begin
          w_div_nxt = r_div + 8'd1;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the pins line up with the state they describe.
    w_dac_val  = w_dac_nxt[6*w_ch_nxt +: 6];
    w_sinp_nxt = 1'b0;
    w_sclk_nxt = 1'b0;
    w_sel_nxt  = 1'b0;
    w_stb_nxt  = 1'b0;
    w_data_nxt = '0;
    w_sgn_nxt  = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_CFG: begin
        w_sinp_nxt = w_cfg_nxt[w_bit_nxt];
        w_sclk_nxt = (w_ph_nxt == 2'd1);
        w_busy_nxt = 1'b1;
      end
      S_DAC: begin
        w_sel_nxt  = 1'b1;
        w_stb_nxt  = (w_ph_nxt == 2'd1);
        w_data_nxt = w_dac_val[4:0];
        w_sgn_nxt  = w_dac_val[5];
        w_busy_nxt = 1'b1;
      end
      S_FIN:   w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  assign bus.sinp         = r_sinp;
  assign bus.sclk         = r_sclk;
  assign bus.sel_ext_addr = r_sel;
  assign bus.dac_stb      = r_stb;
  assign bus.dac_data     = r_data;
  assign bus.dac_sgn      = r_sgn;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
endmodule

// File: tb/tb_load_config_reg_hinp4.sv
// Bench for load_config_reg_hinp4: three instances (DIV=1,2,4) share stimulus; a pin-level
// monitor decodes sclk/strobe activity and is compared against expectations from the timing rules.
module tb_load_config_reg_hinp4;
  localparam int CB = 32;
  localparam int ND = 16;

  logic            clk;
  logic            rst_n;
  logic [2:0]      r_start;
  logic [CB-1:0]   cfg_word;
  logic [6*ND-1:0] dac_values;
  logic            clr;

  logic [2:0] m_sinp, m_sclk, m_sel, m_stb, m_sgn, m_busy, m_done;
  logic [4:0] m_data [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    localparam int DV = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    load_config_reg_hinp4_if #(.CFG_BITS(CB), .NUM_DACS(ND)) u_if ();
    load_config_reg_hinp4 #(.CFG_BITS(CB), .NUM_DACS(ND), .DIV(DV)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
    );
    assign u_if.start      = r_start[g];
    assign u_if.cfg_word   = cfg_word;
    assign u_if.dac_values = dac_values;
    assign m_sinp[g] = u_if.sinp;
    assign m_sclk[g] = u_if.sclk;
    assign m_sel[g]  = u_if.sel_ext_addr;
    assign m_stb[g]  = u_if.dac_stb;
    assign m_sgn[g]  = u_if.dac_sgn;
    assign m_busy[g] = u_if.busy;
    assign m_done[g] = u_if.done;
    assign m_data[g] = u_if.dac_data;
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  function automatic logic [35:0] outs();
    return {m_sinp, m_sclk, m_sel, m_stb, m_sgn, m_busy, m_done, m_data[0], m_data[1], m_data[2]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pin-level monitor statistics
  int n_sclk[3], n_ones[3], n_stb[3], n_done[3], n_selr[3], busy_cnt[3], hi_len[3];
  int bad_hi[3], bad_sinp[3], bad_sel[3], bad_dat[3], bad_idle[3];
  int t_sclk[3], t_sel[3], t_stb[3], t_done[3];
  int rst_bad = 0;
  logic [31:0] rx [3];
  logic [5:0]  seen [3][16];
  logic [2:0]  p_sclk = '0, p_sinp = '0, p_stb = '0, p_sel = '0;
  logic [5:0]  p_val [3];

  always @(negedge clk) begin
    if (!rst_n && outs() != '0) rst_bad++;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        n_sclk[i] = 0; n_ones[i] = 0; n_stb[i] = 0; n_done[i] = 0; n_selr[i] = 0;
        busy_cnt[i] = 0; hi_len[i] = 0; bad_hi[i] = 0; bad_sinp[i] = 0; bad_sel[i] = 0;
        bad_dat[i] = 0; bad_idle[i] = 0; t_sclk[i] = -1; t_sel[i] = -1; t_stb[i] = -1;
        t_done[i] = -1; rx[i] = '0;
      end else begin
        if (m_sclk[i] && !p_sclk[i]) begin
          rx[i] = {rx[i][30:0], m_sinp[i]};
          if (m_sinp[i]) n_ones[i]++;
          if (n_sclk[i] == 0) t_sclk[i] = cyc + 1;
          n_sclk[i]++;
          hi_len[i] = 0;
        end
        if (m_sclk[i]) hi_len[i]++;
        if (!m_sclk[i] && p_sclk[i] && hi_len[i] != div_of(i)) bad_hi[i]++;
        if (m_sclk[i] && p_sclk[i] && m_sinp[i] != p_sinp[i]) bad_sinp[i]++;
        if (m_stb[i] && !p_stb[i]) begin
          if (n_stb[i] < ND) seen[i][n_stb[i]] = {m_sgn[i], m_data[i]};
          if (n_stb[i] == 0) t_stb[i] = cyc + 1;
          n_stb[i]++;
          if (!m_sel[i]) bad_sel[i]++;
        end
        if ((m_stb[i] || p_stb[i]) && {m_sgn[i], m_data[i]} != p_val[i]) bad_dat[i]++;
        if (m_sel[i] && !p_sel[i]) begin
          n_selr[i]++;
          if (n_selr[i] == 1) t_sel[i] = cyc + 1;
        end
        if (m_busy[i]) busy_cnt[i]++;
        if (m_done[i]) begin
          n_done[i]++;
          t_done[i] = cyc + 1;
        end
        if (!m_busy[i] && (m_sinp[i] | m_sclk[i] | m_sel[i] | m_stb[i] | m_sgn[i] | (|m_data[i])))
          bad_idle[i]++;
      end
      p_sclk[i] = m_sclk[i];
      p_sinp[i] = m_sinp[i];
      p_stb[i]  = m_stb[i];
      p_sel[i]  = m_sel[i];
      p_val[i]  = {m_sgn[i], m_data[i]};
    end
  end

  // Expected behaviour of one complete sequence started on edge k.
  task automatic check_seq(input int i, input logic [31:0] c, input logic [95:0] d, input int k);
    int dv;
    int len;
    dv  = div_of(i);
    len = dv * (CB * 2 + ND * 3);
    chk($sformatf("n_sclk%0d", i), n_sclk[i], CB);
    chk($sformatf("cfg_rx%0d", i), rx[i], c);
    chk($sformatf("sclk_hi%0d", i), bad_hi[i], 0);
    chk($sformatf("sinp_hold%0d", i), bad_sinp[i], 0);
    chk($sformatf("n_stb%0d", i), n_stb[i], ND);
    for (int ch = 0; ch < ND; ch++)
      chk($sformatf("dac%0d_ch%0d", i, ch), seen[i][ch], d[6*ch +: 6]);
    chk($sformatf("sel_rises%0d", i), n_selr[i], 1);
    chk($sformatf("stb_sel%0d", i), bad_sel[i], 0);
    chk($sformatf("dat_hold%0d", i), bad_dat[i], 0);
    chk($sformatf("idle_out%0d", i), bad_idle[i], 0);
    chk($sformatf("t_sclk%0d", i), t_sclk[i], k + 1 + dv);
    chk($sformatf("t_sel%0d", i), t_sel[i], k + 1 + CB * 2 * dv);
    chk($sformatf("t_stb%0d", i), t_stb[i], k + 1 + CB * 2 * dv + dv);
    chk($sformatf("t_done%0d", i), t_done[i], k + 1 + len);
    chk($sformatf("n_done%0d", i), n_done[i], 1);
    chk($sformatf("busy_len%0d", i), busy_cnt[i], len);
  endtask

  task automatic run_scn(input int s);
    logic [31:0] c;
    logic [95:0] d;
    int k;
    int lim;
    c = $urandom;
    d = {$urandom, $urandom, $urandom};
    if (s == 0) begin
      c = 32'hA5A5_0F0F;
      for (int i = 0; i < ND; i++) d[6*i +: 6] = {i[0], i[4:0]};
    end
    if (s == 1) begin
      c = '1;
      d[35:30] = 6'h20;
    end
    if (s == 2) c = '0;
    clr = 1'b1; tick(); clr = 1'b0;
    cfg_word = c; dac_values = d; r_start = 3'b111;
    k = cyc + 1;
    tick();
    r_start = 3'b000;
    repeat (9) tick();
    // Request while busy with different data: must be ignored
    cfg_word = ~c; dac_values = ~d; r_start = 3'b111;
    tick();
    r_start = 3'b000;
    lim = 0;
    while (n_done[2] == 0 && lim < 3000) begin tick(); lim++; end
    chk($sformatf("wait_done_s%0d", s), lim < 3000, 1);
    repeat (5) tick();
    for (int i = 0; i < 3; i++) check_seq(i, c, d, k);
  endtask

  task automatic run_b2b();
    int k1;
    int e;
    int lim;
    int len1;
    len1 = CB * 2 + ND * 3;
    clr = 1'b1; tick(); clr = 1'b0;
    cfg_word = '1; dac_values = {$urandom, $urandom, $urandom}; r_start = 3'b001;
    k1 = cyc + 1;
    tick();
    r_start = 3'b000;
    lim = 0;
    while (!m_done[0] && lim < 1000) begin tick(); lim++; end
    chk("b2b_wait1", lim < 1000, 1);
    e = cyc;
    chk("b2b_done1", e + 1, k1 + 1 + len1);
    // First sampling lands on the done cycle (ignored), second is accepted
    r_start = 3'b001;
    tick();
    cfg_word = '0;
    tick();
    r_start = 3'b000;
    lim = 0;
    while (n_done[0] < 2 && lim < 1000) begin tick(); lim++; end
    chk("b2b_wait2", lim < 1000, 1);
    repeat (3) tick();
    chk("b2b_n_sclk", n_sclk[0], 2 * CB);
    chk("b2b_ones", n_ones[0], CB);
    chk("b2b_rx", rx[0], 32'h0);
    chk("b2b_sclk_hi", bad_hi[0], 0);
    chk("b2b_n_stb", n_stb[0], 2 * ND);
    chk("b2b_n_done", n_done[0], 2);
    chk("b2b_done2", t_done[0], e + 2 + 1 + len1);
    chk("b2b_busy", busy_cnt[0], 2 * len1);
  endtask

  task automatic run_abort();
    int lim;
    clr = 1'b1; tick(); clr = 1'b0;
    cfg_word = $urandom; dac_values = {$urandom, $urandom, $urandom}; r_start = 3'b111;
    tick();
    r_start = 3'b000;
    lim = 0;
    while (!m_sel[2] && lim < 1000) begin tick(); lim++; end
    chk("abort_wait_dac", lim < 1000, 1);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1 chk("async_rst_out", outs(), 36'h0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (300) tick();
    chk("abort_no_done", n_done[2], 0);
    chk("abort_idle", m_busy, 3'b000);
  endtask

  initial begin
    rst_n = 1'b1; r_start = '0; clr = 1'b0; cfg_word = '0; dac_values = '0;
    #1 rst_n = 1'b0;
    for (int t = 0; t < 10; t++) begin
      r_start  = (t % 2 == 1) ? 3'b111 : 3'b000;
      cfg_word = $urandom;
      tick();
    end
    r_start = 3'b000;
    chk("rst_state", outs(), 36'h0);
    chk("rst_hold", rst_bad, 0);
    rst_n = 1'b1;
    tick(); tick();
    for (int s = 0; s < 5; s++) run_scn(s);
    run_b2b();
    run_abort();
    run_scn(5);
    chk("rst_window", rst_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
